// File: rtl/wb_cmd_master_if.sv
// Command/response stream plus Wishbone classic bus signals for wb_cmd_master.
// The master modport is the initiator's view; the slave modport is the surrounding environment.
interface wb_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_sel;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel,
        input  rsp_ready, i_wb_ack, i_wb_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel,
        output rsp_ready, i_wb_ack, i_wb_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one command becomes one single read/write cycle and one response.
// A cycle that sees no ack within TIMEOUT strobe cycles is aborted and reported with rsp_err.
module wb_cmd_master #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    wb_cmd_master_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q;
    logic [TO_W-1:0] cnt_q;
    logic           cyc_q;
    logic           we_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     sel_q;
    logic           rsp_valid_q;
    logic [31:0]    rsp_data_q;
    logic           rsp_err_q;

    // cnt_q counts strobe cycles already spent without ack; ack has priority over the abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        we_q    <= bus.cmd_we;
                        addr_q  <= bus.cmd_addr;
                        wdata_q <= bus.cmd_we ? bus.cmd_data : 32'h0;
                        sel_q   <= bus.cmd_sel;
                        cyc_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    if (bus.i_wb_ack) begin
                        cyc_q       <= 1'b0;
                        rsp_data_q  <= we_q ? 32'h0 : bus.i_wb_data;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                        cyc_q       <= 1'b0;
                        rsp_data_q  <= 32'h0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == IDLE) & ~reset;
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.o_wb_cyc  = cyc_q;
    assign bus.o_wb_stb  = cyc_q;
    assign bus.o_wb_we   = we_q;
    assign bus.o_wb_addr = addr_q;
    assign bus.o_wb_data = wdata_q;
    assign bus.o_wb_sel  = sel_q;

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic initiator: turns a simple command stream into single Wishbone read/write cycles and returns a response for each command.
- Drives peripheral slaves such as the button/LED register block from internal sequencers, the LA-driven test harness, or a future CPU-less controller.
- One transaction in flight at a time.
- Bus timeout protects against slaves that never acknowledge.

Parameters:
- TIMEOUT, 255: number of cycles cyc/stb may stay asserted without ack before the cycle is aborted with an error (legal range 2..65535).
- TO_W, 16: width of the internal timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  master can accept a command.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_addr  input  32  byte address.
- cmd_data  input  32  write data (ignored for reads).
- cmd_sel  input  4  byte lane selects.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  32  read data (0 for writes and errors).
- rsp_err  output  1  1 = timeout abort.
- busy  output  1  high from command accept until response handed off.
- o_wb_cyc  output  1  Wishbone cycle.
- o_wb_stb  output  1  Wishbone strobe.
- o_wb_we  output  1  Wishbone write enable.
- o_wb_addr  output  32  Wishbone address.
- o_wb_data  output  32  Wishbone write data.
- o_wb_sel  output  4  Wishbone byte selects.
- i_wb_ack  input  1  slave acknowledge.
- i_wb_data  input  32  slave read data.

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-high.
- Reset values:
  - All o_wb_* = 0; rsp_valid = 0, rsp_data = 0, rsp_err = 0.
  - busy = 0; state = IDLE; timeout counter = 0.
  - cmd_ready = 0 while reset is asserted, 1 after release.
- All outputs are registered except cmd_ready and busy:
  - cmd_ready = (state == IDLE) & ~reset.
  - busy = (state != IDLE).
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - On cmd_valid & cmd_ready at an edge: latch we/addr/data/sel onto o_wb_we/o_wb_addr/o_wb_data/o_wb_sel.
  - Same edge: set o_wb_cyc = o_wb_stb = 1, clear counter, go to BUS.
  - For reads, o_wb_data is loaded with 0.
- BUS:
  - Address, data, we and sel are held stable.
  - Counter increments every cycle without ack.
  - i_wb_ack = 1 at an edge: cyc/stb = 0 after that edge. For reads, rsp_data <= i_wb_data; for writes, rsp_data <= 0. rsp_err <= 0, rsp_valid <= 1, go to RESP.
  - Counter == TIMEOUT-1 with no ack (i.e. TIMEOUT cycles of stb with no ack): cyc/stb = 0, rsp_data <= 0, rsp_err <= 1, rsp_valid <= 1, go to RESP.
  - Ack and timeout in the same cycle: ack wins, rsp_err = 0.
- RESP:
  - rsp_valid, rsp_data and rsp_err are held until rsp_ready = 1 at an edge.
  - Then rsp_valid <= 0 and state goes to IDLE; a new command can be accepted on the following edge (no same-edge bypass).
- Latency, zero-wait slave: accept at edge N; cyc/stb high N..N+1; ack sampled at N+1; rsp_valid high after N+1. Minimum 3 cycles per transaction with rsp_ready tied high.
- i_wb_ack outside BUS is ignored.
- i_wb_data is sampled only on the ack edge of a read.
- cmd_* inputs are ignored outside IDLE.
- o_wb_stb always equals o_wb_cyc (classic, no pipelining, no retry/err inputs).
- Reset mid-transaction: cyc/stb drop immediately (asynchronous); any pending response is discarded; state returns to IDLE.

Test Plan:
- Write: cmd we=1, addr=0x3000_0000, data=0xA5, sel=0xF; slave acks on 2nd stb cycle -> exactly one cyc/stb window of 2 cycles with addr/data/we stable; rsp_valid with rsp_err=0, rsp_data=0.
- Read: cmd we=0, addr=0x3000_0004; zero-wait slave returns 0x0000_0005 -> o_wb_data=0 during cycle; rsp_data=0x5 one cycle after ack; 3 cycles accept-to-idle.
- Timeout: TIMEOUT=8, slave never acks -> stb high exactly 8 cycles, then dropped; rsp_err=1, rsp_data=0; a following read to a responsive slave succeeds.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp held stable, cmd_ready=0, busy=1 throughout; a second cmd_valid is not accepted until the edge after the rsp handshake.
- Ack on the final timeout cycle (ack at cycle TIMEOUT) -> rsp_err=0, read data captured.
- Reset asserted while stb=1 -> cyc/stb=0 without waiting for a clock edge; rsp_valid=0; cmd_ready=1 after release; a later ack pulse is ignored.
